reg_writeback_unit: RTL and testbench
=====================================

// Module: reg_writeback_unit
// PURPOSE
//  Write-side sequencer for the 8x16 register file: queues writeback requests from
//  datapath producers (ALU, memory load, PC-link), drains them one per cycle onto the
//  register-file write port (DRMUX/LD_REG/BUSINPUT), keeps the LC-3 NZP condition codes,
//  and publishes per-register pending bits so the operand-read side can stall on hazards.
// PARAMETERS
//  DEPTH   4   request FIFO entries (power of 2, >=2)
//  WIDTH   16  data width
// PORTS
//  clk        in   1      system clock, all state on rising edge
//  reset_n    in   1      synchronous, active-low reset
//  wb_valid   in   1      producer has a writeback request
//  wb_ready   out  1      unit can accept; transfer when wb_valid&&wb_ready
//  wb_dr      in   3      destination register
//  wb_data    in   WIDTH  value to write
//  wb_setcc   in   1      this write also updates NZP
//  stall      in   1      hold draining (bus/regfile port owned elsewhere)
//  flush      in   1      discard all queued, undrained requests
//  DRMUX      out  3      regfile destination select
//  LD_REG     out  1      regfile write enable
//  BUSINPUT   out  WIDTH  regfile write data
//  NZP        out  3      {N,Z,P} condition codes
//  busy       out  8      busy[i]=1: register i has an undrained write pending
//  empty      out  1      FIFO holds no entries
// BEHAVIOUR
//  Reset (reset_n=0 at edge): FIFO emptied, LD_REG=0, DRMUX=0, BUSINPUT=0, NZP=3'b010,
//   busy=0, empty=1; wb_ready=0 while reset_n=0, wb_ready=1 in first cycle after.
//  wb_ready = !full && !flush && reset_n; based on registered count only (no
//   same-cycle pop credit). A full FIFO takes a new request the cycle after a pop.
//  FIFO: circular, DEPTH entries of {dr,data,setcc}; rd/wr pointers wrap modulo DEPTH;
//   count 0..DEPTH. Simultaneous push+pop leaves count unchanged; legal when nonempty.
//  Drain: each edge with !empty && !stall && !flush, head pops and registers
//   LD_REG=1, DRMUX=head.dr, BUSINPUT=head.data; otherwise LD_REG=0 and DRMUX/BUSINPUT hold.
//   Latency: request accepted at edge t into empty FIFO -> LD_REG=1 in cycle t+1..t+2
//   (visible after edge t+1). Requests drain in strict acceptance order; never merged.
//  NZP: updated on the same edge that pops a setcc entry, from head.data:
//   data[15]=1 -> 100; data==0 -> 010; else 001. Non-setcc pops leave NZP unchanged.
//  busy: per-register pending count (0..DEPTH). +1 on acceptance to wb_dr, -1 on pop of
//   entry with that dr; both same reg same edge -> unchanged. busy[i]=(count_i!=0).
//   busy rises the cycle after acceptance, falls after the edge that raises LD_REG.
//   Register written this cycle is guaranteed to read new value next cycle.
//  stall: freezes pointers/contents; pushes still accepted while not full.
//  flush (sync, highest priority below reset): at edge, FIFO emptied, all busy
//   counts cleared, LD_REG=0; concurrent wb_valid dropped (wb_ready=0); NZP retained.
//  Back-to-back writes to the same dr both drain (second wins); busy stays high through both.
//  Reset mid-drain: LD_REG drops at that edge; no partial writes; queued entries lost.
// TESTING
//  1. Reset then wb_dr=3,data=16'h8001,setcc=1 one cycle -> next cycle LD_REG=1,DRMUX=3,
//     BUSINPUT=8001, NZP=100; busy[3]=1 for 1 cycle then 0; empty=1 after.
//  2. stall=1, push 4 requests (R0..R3, data 0,1,2,3, setcc=1) -> 4th cycle wb_ready=0,
//     busy=8'h0F; release stall -> LD_REG 4 cycles, DRMUX 0,1,2,3 in order, final NZP=001.
//  3. Full FIFO, hold wb_valid with R5 -> accepted exactly the cycle after first pop;
//     order preserved; pointers wrap correctly over 3 full fill/drain passes.
//  4. Two writes R2 (data 5 then 0, setcc=1) back-to-back -> busy[2] high until second
//     LD_REG cycle; NZP 001 then 010.
//  5. 3 queued entries, flush=1 with wb_valid=1 -> next cycle LD_REG=0, busy=0, empty=1,
//     NZP unchanged, flushed-cycle request not written.
//  6. reset_n=0 mid-drain with 2 entries -> all outputs reset values next cycle.

Source files
------------

// File: rtl/reg_writeback_if.sv
// Writeback request channel between datapath producers and the writeback unit.
//   wb_valid  producer has a request
//   wb_ready  unit can accept (transfer on wb_valid && wb_ready)
//   wb_dr     destination register
//   wb_data   value to write
//   wb_setcc  request also updates NZP
interface reg_writeback_if #(
  parameter int unsigned WIDTH = 16
);
  logic             wb_valid;
  logic             wb_ready;
  logic [2:0]       wb_dr;
  logic [WIDTH-1:0] wb_data;
  logic             wb_setcc;

  modport master (output wb_valid, wb_dr, wb_data, wb_setcc, input wb_ready);
  modport slave  (input wb_valid, wb_dr, wb_data, wb_setcc, output wb_ready);
endinterface

// File: rtl/reg_writeback_unit.sv
// Write-side sequencer for the 8x16 register file. Queues writeback requests in a
// small FIFO, drains one per cycle onto the regfile write port, keeps NZP and
// publishes per-register pending bits for hazard stalls.
//   clk, reset_n  clock and synchronous active-low reset
//   wb            request channel (slave side)
//   stall, flush  hold draining / discard all queued requests
//   DRMUX, LD_REG, BUSINPUT  regfile write port
//   NZP           condition codes {N,Z,P}
//   busy          per-register pending-write flags
//   empty         FIFO holds no entries
module reg_writeback_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  reg_writeback_if.slave   wb,
  input  logic             stall,
  input  logic             flush,
  output logic [2:0]       DRMUX,
  output logic             LD_REG,
  output logic [WIDTH-1:0] BUSINPUT,
  output logic [2:0]       NZP,
  output logic [7:0]       busy,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned NREG  = 8;

  typedef struct packed {
    logic [2:0]       dr;
    logic [WIDTH-1:0] data;
    logic             setcc;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0] pend     [NREG];
  logic [CNT_W-1:0] pend_nxt [NREG];
  logic [NREG-1:0]  busy_nxt;
  logic [NREG-1:0]  inc;
  logic [NREG-1:0]  dec;
  logic             full;
  logic             push;
  logic             pop;
  entry_t           head;
  logic [2:0]       nzp_head;

  // Ready uses the registered count only; a pop does not free a slot until the next cycle.
  assign full        = (count == CNT_W'(DEPTH));
  assign wb.wb_ready = !full && !flush && reset_n;
  assign push        = wb.wb_valid && wb.wb_ready;
  assign pop         = (count != '0) && !stall && !flush;
  assign head        = mem[rd_ptr];

  assign inc = push ? (NREG'(1) << wb.wb_dr) : '0;
  assign dec = pop  ? (NREG'(1) << head.dr)  : '0;

  // Condition codes derived from the head entry's data.
  always_comb begin
    nzp_head = 3'b001;
    if (head.data[WIDTH-1])     nzp_head = 3'b100;
    else if (head.data == '0)   nzp_head = 3'b010;
  end

  // Next occupancy and per-register pending counts.
  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CNT_W'(1);
    else if (!push && pop) count_nxt = count - CNT_W'(1);
    busy_nxt = '0;
    for (int i = 0; i < NREG; i++) begin
      pend_nxt[i] = pend[i];
      if (inc[i] && !dec[i])      pend_nxt[i] = pend[i] + CNT_W'(1);
      else if (!inc[i] && dec[i]) pend_nxt[i] = pend[i] - CNT_W'(1);
      busy_nxt[i] = (pend_nxt[i] != '0);
    end
  end

  // FIFO storage; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{dr: wb.wb_dr, data: wb.wb_data, setcc: wb.wb_setcc};
  end

  // Control state, write port and condition codes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < NREG; i++) pend[i] <= '0;
      LD_REG   <= 1'b0;
      DRMUX    <= 3'd0;
      BUSINPUT <= '0;
      NZP      <= 3'b010;
      busy     <= '0;
      empty    <= 1'b1;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < NREG; i++) pend[i] <= '0;
      LD_REG <= 1'b0;
      busy   <= '0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        LD_REG   <= 1'b1;
        DRMUX    <= head.dr;
        BUSINPUT <= head.data;
        if (head.setcc) NZP <= nzp_head;
      end else begin
        LD_REG <= 1'b0;
      end
      count <= count_nxt;
      for (int i = 0; i < NREG; i++) pend[i] <= pend_nxt[i];
      busy  <= busy_nxt;
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Bench for reg_writeback_unit: directed scenarios followed by random traffic, all
// compared each cycle against a queue-based reference model.
module tb_reg_writeback_unit;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             stall;
  logic             flush;
  logic [2:0]       DRMUX;
  logic             LD_REG;
  logic [WIDTH-1:0] BUSINPUT;
  logic [2:0]       NZP;
  logic [7:0]       busy;
  logic             empty;

  reg_writeback_if #(.WIDTH(WIDTH)) wb ();

  reg_writeback_unit #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wb       (wb),
    .stall    (stall),
    .flush    (flush),
    .DRMUX    (DRMUX),
    .LD_REG   (LD_REG),
    .BUSINPUT (BUSINPUT),
    .NZP      (NZP),
    .busy     (busy),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  dr;
    logic [15:0] data;
    logic        setcc;
  } ent_t;

  ent_t        q[$];
  logic        m_ld;
  logic [2:0]  m_dr;
  logic [15:0] m_bus;
  logic [2:0]  m_nzp;
  int          n_assert = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] dr, input logic [15:0] d,
                       input logic sc, input logic st, input logic fl, input logic rn);
    wb.wb_valid = v;
    wb.wb_dr    = dr;
    wb.wb_data  = d;
    wb.wb_setcc = sc;
    stall       = st;
    flush       = fl;
    reset_n     = rn;
  endtask

  function automatic logic [2:0] cc_of(input logic [15:0] d);
    if (d[15])          return 3'b100;
    else if (d == 16'd0) return 3'b010;
    else                return 3'b001;
  endfunction

  // One clock: check ready, advance the model, then check all registered outputs.
  task automatic cycle();
    bit       acc;
    ent_t     e;
    logic [7:0] exp_busy;
    #1;
    check("wb_ready", 32'(wb.wb_ready), 32'(reset_n && !flush && (q.size() < DEPTH)));
    acc = wb.wb_valid && reset_n && !flush && (q.size() < DEPTH);
    if (!reset_n) begin
      q.delete();
      m_ld = 1'b0; m_dr = 3'd0; m_bus = 16'd0; m_nzp = 3'b010;
    end else if (flush) begin
      q.delete();
      m_ld = 1'b0;
    end else begin
      if (q.size() > 0 && !stall) begin
        e = q.pop_front();
        m_ld = 1'b1; m_dr = e.dr; m_bus = e.data;
        if (e.setcc) m_nzp = cc_of(e.data);
      end else begin
        m_ld = 1'b0;
      end
      if (acc) q.push_back('{dr: wb.wb_dr, data: wb.wb_data, setcc: wb.wb_setcc});
    end
    exp_busy = 8'h00;
    foreach (q[k]) exp_busy[q[k].dr] = 1'b1;
    @(posedge clk);
    #1;
    check("LD_REG",   32'(LD_REG),   32'(m_ld));
    check("DRMUX",    32'(DRMUX),    32'(m_dr));
    check("BUSINPUT", 32'(BUSINPUT), 32'(m_bus));
    check("NZP",      32'(NZP),      32'(m_nzp));
    check("busy",     32'(busy),     32'(exp_busy));
    check("empty",    32'(empty),    32'(q.size() == 0));
  endtask

  initial begin
    drive(1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    m_ld = 1'b0; m_dr = 3'd0; m_bus = 16'd0; m_nzp = 3'b010;
    @(posedge clk); #1;

    // Reset, then a single setcc write to R3 with a negative value.
    repeat (2) cycle();
    drive(1'b1, 3'd3, 16'h8001, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle();
    check("t1_busy3", 32'(busy), 32'h08);
    drive(1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle();
    check("t1_ld",  32'(LD_REG),   32'd1);
    check("t1_dr",  32'(DRMUX),    32'd3);
    check("t1_bus", 32'(BUSINPUT), 32'h8001);
    check("t1_nzp", 32'(NZP),      32'b100);
    check("t1_busy_clear", 32'(busy), 32'h00);
    repeat (2) cycle();

    // Fill under stall, then release and drain in order.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'(i), 16'(i), 1'b1, 1'b1, 1'b0, 1'b1);
      cycle();
    end
    check("t2_busy", 32'(busy), 32'h0F);
    check("t2_ready_full", 32'(wb.wb_ready), 32'd0);
    drive(1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (5) cycle();
    check("t2_nzp", 32'(NZP), 32'b001);

    // Full FIFO with R5 held: three fill/drain passes exercising pointer wrap.
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 4; i++) begin
        drive(1'b1, 3'(i), 16'(16'h100 * p + i), 1'(i[0]), 1'b1, 1'b0, 1'b1);
        cycle();
      end
      drive(1'b1, 3'd5, 16'h0055, 1'b1, 1'b0, 1'b0, 1'b1);
      cycle();
      cycle();
      drive(1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (6) cycle();
    end

    // Back-to-back writes to R2, NZP 001 then 010.
    drive(1'b1, 3'd2, 16'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle();
    drive(1'b1, 3'd2, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle();
    check("t4_nzp1", 32'(NZP), 32'b001);
    check("t4_busy2", 32'(busy[2]), 32'd1);
    drive(1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle();
    check("t4_nzp2", 32'(NZP), 32'b010);
    repeat (2) cycle();

    // Flush with three queued entries and a concurrent request.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'(i + 4), 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1);
      cycle();
    end
    drive(1'b1, 3'd1, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b1);
    cycle();
    check("t5_empty", 32'(empty), 32'd1);
    check("t5_busy",  32'(busy),  32'h00);
    check("t5_nzp",   32'(NZP),   32'b010);
    drive(1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) cycle();

    // Reset mid-drain.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 3'(i + 6), 16'h0007, 1'b1, 1'b1, 1'b0, 1'b1);
      cycle();
    end
    drive(1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle();
    drive(1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    check("t6_ld",  32'(LD_REG), 32'd0);
    check("t6_nzp", 32'(NZP),    32'b010);
    check("t6_busy", 32'(busy),  32'h00);
    drive(1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      logic [15:0] d;
      d = 16'($urandom);
      if ($urandom_range(0, 3) == 0) d = 16'd0;
      drive(1'($urandom_range(0, 99) < 60), 3'($urandom), d, 1'($urandom),
            1'($urandom_range(0, 99) < 30), 1'($urandom_range(0, 99) < 4),
            1'($urandom_range(0, 99) >= 2));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
